// File: rtl/game_pkg.sv
// Shared game constants: LFSR geometry, default seed, lane count and lane index type.
package game_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam int DEFAULT_NUM_LANES = 3;

  typedef logic [1:0] lane_t;

  // Feedback bit for x^16+x^14+x^13+x^11+1 in Fibonacci form.
  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] v);
    return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next-state for the 16-bit lane LFSR: shift, optional entropy
// injection, and recovery from the all-zero lock-up state.
module lfsr16_step
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic [LFSR_W-1:0] cur,
  input  logic              inject,
  input  logic [LFSR_W-1:0] inject_val,
  output logic [LFSR_W-1:0] nxt
);

  logic [LFSR_W-1:0] shifted;
  logic [LFSR_W-1:0] candidate;

  // Shift, fold in entropy on a capture, and never let the register reach zero.
  always_comb begin
    shifted   = {cur[LFSR_W-2:0], lfsr_feedback(cur)};
    candidate = shifted;
    nxt       = SEED;
    if (inject) begin
      candidate = shifted ^ inject_val;
    end else begin
      candidate = shifted;
    end
    if (candidate == 16'h0000) begin
      nxt = SEED;
    end else begin
      nxt = candidate;
    end
  end

endmodule

// File: rtl/random_enemy_lane_rng.sv
// Lane selector for new enemies: free-running LFSR mixed with ammo/time on
// each rising edge of trigger, reduced modulo the lane count into a register.
module random_enemy_lane_rng
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int                NUM_LANES = DEFAULT_NUM_LANES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] ammo,
  input  logic [7:0] tm,
  output logic [1:0] rng
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic              trig_q;
  logic              capture;
  logic [7:0]        mix;

  // 8-bit unsigned modulo, narrowed to the lane index width.
  function automatic lane_t lane_of(input logic [7:0] m);
    logic [7:0] r;
    r = m % 8'(NUM_LANES);
    return lane_t'(r);
  endfunction

  assign capture = trigger & ~trig_q;
  assign mix     = lfsr[7:0] ^ ammo ^ {tm[3:0], tm[7:4]};

  lfsr16_step #(
    .SEED(SEED)
  ) u_step (
    .cur       (lfsr),
    .inject    (capture),
    .inject_val({tm, ammo}),
    .nxt       (lfsr_next)
  );

  // State update; reset wins over a coincident trigger rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr   <= SEED;
      trig_q <= 1'b0;
      rng    <= 2'd0;
    end else begin
      trig_q <= trigger;
      lfsr   <= lfsr_next;
      if (capture) begin
        rng <= lane_of(mix);
      end
    end
  end

endmodule

// File: tb/tb_random_enemy_lane_rng.sv
// Self-checking bench: directed cases plus a randomized run against a
// cycle-level behavioural model of the lane selector.
module tb_random_enemy_lane_rng;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int LANES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic [7:0] ammo;
  logic [7:0] tm;
  logic [1:0] rng;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_lfsr;
  int m_tq;
  int m_rng;
  int seen [3];

  random_enemy_lane_rng #(.SEED(SEED), .NUM_LANES(LANES)) dut (
    .clk    (clk),
    .reset  (reset),
    .trigger(trigger),
    .ammo   (ammo),
    .tm     (tm),
    .rng    (rng)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int advance(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) % 65536) + fb;
  endfunction

  function automatic int nibble_swap(input int v);
    return (v % 16) * 16 + (v / 16);
  endfunction

  function automatic int lane_pick(input int l, input int a, input int t);
    return ((l % 256) ^ a ^ nibble_swap(t)) % LANES;
  endfunction

  // One clock edge: the model consumes the inputs present at the edge.
  task automatic tick();
    int nxt;
    @(posedge clk);
    if (reset) begin
      m_lfsr = SEED;
      m_tq   = 0;
      m_rng  = 0;
    end else begin
      nxt = advance(m_lfsr);
      if (trigger && m_tq == 0) begin
        m_rng = lane_pick(m_lfsr, ammo, tm);
        nxt   = nxt ^ (tm * 256 + ammo);
      end
      if (nxt == 0) nxt = SEED;
      m_lfsr = nxt;
      m_tq   = trigger ? 1 : 0;
    end
    #1;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_rng"}, 32'(rng), 32'(m_rng));
    check_val({tag, "_lfsr"}, 32'(dut.lfsr), 32'(m_lfsr));
    check_val({tag, "_trigq"}, 32'(dut.trig_q), 32'(m_tq));
  endtask

  task automatic do_reset();
    reset = 1'b1; trigger = 1'b0; ammo = 8'h00; tm = 8'h00;
    tick();
    tick();
    check_val("reset_rng", 32'(rng), 32'd0);
    check_val("reset_lfsr", 32'(dut.lfsr), 32'(SEED));
    check_val("reset_trigq", 32'(dut.trig_q), 32'd0);
    reset = 1'b0;
  endtask

  task automatic first_capture(input logic [7:0] a, input logic [7:0] t, input int exp_lane);
    do_reset();
    trigger = 1'b1; ammo = a; tm = t;
    tick();
    check_val("first_capture_lane", 32'(rng), 32'(exp_lane));
    check_state("first_capture");
  endtask

  initial begin
    int prev;
    int changes;
    int sh;
    int a;

    m_lfsr = 0; m_tq = 0; m_rng = 0;
    reset = 1'b1; trigger = 1'b0; ammo = 8'h00; tm = 8'h00;

    // Directed first captures straight out of reset
    first_capture(8'h00, 8'h00, 0);
    check_val("first_lfsr_const", 32'(dut.lfsr), 32'h59C3);
    first_capture(8'h01, 8'h00, 2);
    first_capture(8'h03, 8'h00, 1);
    first_capture(8'h3C, 8'h3C, 0);

    // Held trigger: one capture only, then a low cycle re-arms
    first_capture(8'h01, 8'h00, 2);
    changes = 0;
    prev = 32'(rng);
    for (int i = 0; i < 9; i++) begin
      ammo = 8'($urandom); tm = 8'($urandom);
      tick();
      check_state("hold");
      if (32'(rng) != prev) changes++;
      prev = 32'(rng);
    end
    check_val("hold_no_extra_capture", 32'(changes), 32'd0);
    trigger = 1'b0;
    tick();
    check_state("hold_low");
    tm = 8'h00;
    a = 0;
    while (a < 255 && lane_pick(m_lfsr, a, 0) == m_rng) a++;
    ammo = 8'(a);
    prev = 32'(rng);
    trigger = 1'b1;
    tick();
    check_val("second_capture_changed", 32'(32'(rng) != prev), 32'd1);
    check_state("second_capture");

    // Zero-lock: injected entropy cancels the shifted value exactly
    trigger = 1'b0;
    tick();
    sh = advance(m_lfsr);
    tm = 8'(sh / 256); ammo = 8'(sh % 256);
    trigger = 1'b1;
    tick();
    check_val("zero_lock_seed", 32'(dut.lfsr), 32'(SEED));
    check_state("zero_lock");

    // Reset coincident with a trigger rise
    trigger = 1'b0; ammo = 8'h5A; tm = 8'hA5;
    tick();
    reset = 1'b1; trigger = 1'b1;
    tick();
    check_val("reset_rise_rng", 32'(rng), 32'd0);
    check_val("reset_rise_lfsr", 32'(dut.lfsr), 32'(SEED));
    check_val("reset_rise_trigq", 32'(dut.trig_q), 32'd0);
    reset = 1'b0;
    tick();
    check_state("post_reset_capture");

    // Randomized free run with periodic trigger pulses
    for (int k = 0; k < 3; k++) seen[k] = 0;
    for (int i = 0; i < 6000; i++) begin
      trigger = ((i % 7) == 0) || ((i % 7) == 1 && $urandom_range(0, 1) == 1);
      ammo = 8'($urandom);
      tm = 8'($urandom);
      tick();
      check_state("random");
      check_val("random_lane_range", 32'(rng < 2'd3), 32'd1);
      check_val("random_lfsr_nonzero", 32'(dut.lfsr != 16'h0000), 32'd1);
      if (rng < 2'd3) seen[rng] = 1;
    end
    for (int k = 0; k < 3; k++) check_val("lane_seen", 32'(seen[k]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
